// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch (pc) and load/store ports.
// Optional build macro MEM_ARB_PERF_EN adds the o_conflict_cnt performance counter.
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_pc_addr,
    input  logic          i_pc_rd,
    output logic          o_pc_waitreq,
    output logic [DW-1:0] o_pc_rddata,
    output logic          o_pc_rddatavalid,
    input  logic [AW-1:0] i_ldst_addr,
    input  logic          i_ldst_rd,
    input  logic          i_ldst_wr,
    input  logic [DW-1:0] i_ldst_wrdata,
    output logic          o_ldst_waitreq,
    output logic [DW-1:0] o_ldst_rddata,
    output logic          o_ldst_rddatavalid,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic [DW-1:0] o_mem_wrdata,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]   o_conflict_cnt,
`endif
    input  logic [DW-1:0] i_mem_rddata
);

    localparam int unsigned SW = 4;
    localparam int unsigned TW = 2;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    localparam logic [TW-1:0] IDLE      = 2'd0;
    localparam logic [TW-1:0] PC_PEND   = 2'd1;
    localparam logic [TW-1:0] LDST_PEND = 2'd2;

    logic          pc_req;
    logic          ldst_req;
    logic          grant_pc;
    logic          grant_ldst;
    logic          pc_valid;
    logic          ldst_valid;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [TW-1:0] rd_tag;
    logic [TW-1:0] rd_tag_nxt;
    logic [DW-1:0] pc_rddata_q;
    logic [DW-1:0] ldst_rddata_q;

    // Grant: ldst wins conflicts until pc has been denied MAX_STARVE cycles in a row.
    always_comb begin
        pc_req     = i_pc_rd;
        ldst_req   = i_ldst_rd | i_ldst_wr;
        grant_pc   = 1'b0;
        grant_ldst = 1'b0;
        if (reset) begin
            if (ldst_req && (!pc_req || (starve_cnt < STARVE_MAX))) begin
                grant_ldst = 1'b1;
            end else if (pc_req) begin
                grant_pc = 1'b1;
            end
        end
    end

    // Memory drive and back-pressure for the current cycle.
    always_comb begin
        o_mem_addr = '0;
        if (grant_pc) begin
            o_mem_addr = i_pc_addr;
        end else if (grant_ldst) begin
            o_mem_addr = i_ldst_addr;
        end
        o_mem_rd       = grant_pc | (grant_ldst & ~i_ldst_wr);
        o_mem_wr       = grant_ldst & i_ldst_wr;
        o_mem_wrdata   = i_ldst_wrdata;
        o_pc_waitreq   = reset & pc_req & ~grant_pc;
        o_ldst_waitreq = reset & ldst_req & ~grant_ldst;
    end

    // Next starve count and read-return tag.
    always_comb begin
        starve_nxt = '0;
        if (pc_req && !grant_pc) begin
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
        end
        rd_tag_nxt = IDLE;
        if (grant_pc) begin
            rd_tag_nxt = PC_PEND;
        end else if (grant_ldst && !i_ldst_wr) begin
            rd_tag_nxt = LDST_PEND;
        end
    end

    // Read data passes straight through in the return cycle; otherwise each port holds its last word.
    always_comb begin
        pc_valid           = reset & (rd_tag == PC_PEND);
        ldst_valid         = reset & (rd_tag == LDST_PEND);
        o_pc_rddatavalid   = pc_valid;
        o_ldst_rddatavalid = ldst_valid;
        o_pc_rddata        = pc_valid ? i_mem_rddata : pc_rddata_q;
        o_ldst_rddata      = ldst_valid ? i_mem_rddata : ldst_rddata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt    <= '0;
            rd_tag        <= IDLE;
            pc_rddata_q   <= '0;
            ldst_rddata_q <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            rd_tag     <= rd_tag_nxt;
            if (pc_valid) begin
                pc_rddata_q <= i_mem_rddata;
            end
            if (ldst_valid) begin
                ldst_rddata_q <= i_mem_rddata;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_cnt;

    // Counts every cycle both ports request, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (pc_req && ldst_req) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign o_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] i_pc_addr;
    logic          i_pc_rd;
    logic          o_pc_waitreq;
    logic [DW-1:0] o_pc_rddata;
    logic          o_pc_rddatavalid;
    logic [AW-1:0] i_ldst_addr;
    logic          i_ldst_rd;
    logic          i_ldst_wr;
    logic [DW-1:0] i_ldst_wrdata;
    logic          o_ldst_waitreq;
    logic [DW-1:0] o_ldst_rddata;
    logic          o_ldst_rddatavalid;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_rd;
    logic          o_mem_wr;
    logic [DW-1:0] o_mem_wrdata;
    logic [DW-1:0] i_mem_rddata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0]   o_conflict_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MAXS)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_pc_addr          (i_pc_addr),
        .i_pc_rd            (i_pc_rd),
        .o_pc_waitreq       (o_pc_waitreq),
        .o_pc_rddata        (o_pc_rddata),
        .o_pc_rddatavalid   (o_pc_rddatavalid),
        .i_ldst_addr        (i_ldst_addr),
        .i_ldst_rd          (i_ldst_rd),
        .i_ldst_wr          (i_ldst_wr),
        .i_ldst_wrdata      (i_ldst_wrdata),
        .o_ldst_waitreq     (o_ldst_waitreq),
        .o_ldst_rddata      (o_ldst_rddata),
        .o_ldst_rddatavalid (o_ldst_rddatavalid),
        .o_mem_addr         (o_mem_addr),
        .o_mem_rd           (o_mem_rd),
        .o_mem_wr           (o_mem_wr),
        .o_mem_wrdata       (o_mem_wrdata),
`ifdef MEM_ARB_PERF_EN
        .o_conflict_cnt     (o_conflict_cnt),
`endif
        .i_mem_rddata       (i_mem_rddata)
    );

    // Power-on memory contents: a few fixed words, a hash everywhere else.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h1234;
            16'h0200: return 16'hAAAA;
            16'h0004: return 16'h5555;
            default:  return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    // Memory device: read data appears the cycle after o_mem_rd, garbage otherwise.
    bit          mem_written [65536];
    logic [15:0] mem_data    [65536];
    always @(posedge clk) begin
        if (o_mem_wr) begin
            mem_data[o_mem_addr]    <= o_mem_wrdata;
            mem_written[o_mem_addr] <= 1'b1;
        end
        if (o_mem_rd) begin
            i_mem_rddata <= mem_written[o_mem_addr] ? mem_data[o_mem_addr] : init_word(o_mem_addr);
        end else begin
            i_mem_rddata <= 16'($urandom);
        end
    end

    // Reference model state.
    bit          ref_written [65536];
    logic [15:0] ref_data    [65536];
    int unsigned m_starve;
    int          m_pend;          // 0 none, 1 pc, 2 ldst
    logic [15:0] m_pend_data;
    logic [15:0] m_pc_last;
    logic [15:0] m_ldst_last;
    logic [15:0] m_conf;

    int          winner;          // 0 none, 1 pc, 2 ldst
    logic        e_pc_req, e_ldst_req;
    logic [15:0] e_addr;
    logic        e_rd, e_wr, e_pcw, e_lw, e_pcv, e_lv;
    logic [15:0] e_pcd, e_ld;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_written[a] ? ref_data[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compute_exp;
        e_pc_req   = i_pc_rd;
        e_ldst_req = i_ldst_rd | i_ldst_wr;
        winner     = 0;
        if (reset) begin
            if (e_ldst_req && !(e_pc_req && m_starve == MAXS)) winner = 2;
            else if (e_pc_req) winner = 1;
        end
        e_addr = (winner == 1) ? i_pc_addr : (winner == 2) ? i_ldst_addr : 16'h0000;
        e_rd   = (winner == 1) || (winner == 2 && !i_ldst_wr);
        e_wr   = (winner == 2) && i_ldst_wr;
        e_pcw  = reset && e_pc_req && winner != 1;
        e_lw   = reset && e_ldst_req && winner != 2;
        e_pcv  = reset && m_pend == 1;
        e_lv   = reset && m_pend == 2;
        e_pcd  = e_pcv ? m_pend_data : m_pc_last;
        e_ld   = e_lv ? m_pend_data : m_ldst_last;
    endtask

    task automatic compare_all;
        compute_exp();
        check("mem_addr",   32'(o_mem_addr),         32'(e_addr));
        check("mem_rd",     32'(o_mem_rd),           32'(e_rd));
        check("mem_wr",     32'(o_mem_wr),           32'(e_wr));
        check("mem_wrdata", 32'(o_mem_wrdata),       32'(i_ldst_wrdata));
        check("pc_wait",    32'(o_pc_waitreq),       32'(e_pcw));
        check("ldst_wait",  32'(o_ldst_waitreq),     32'(e_lw));
        check("pc_valid",   32'(o_pc_rddatavalid),   32'(e_pcv));
        check("pc_data",    32'(o_pc_rddata),        32'(e_pcd));
        check("ldst_valid", 32'(o_ldst_rddatavalid), 32'(e_lv));
        check("ldst_data",  32'(o_ldst_rddata),      32'(e_ld));
`ifdef MEM_ARB_PERF_EN
        check("conflict",   32'(o_conflict_cnt),     32'(m_conf));
`endif
    endtask

    task automatic model_update;
        compute_exp();
        if (!reset) begin
            m_starve    = 0;
            m_pend      = 0;
            m_pc_last   = 16'h0000;
            m_ldst_last = 16'h0000;
            m_conf      = 16'h0000;
        end else begin
            if (e_pcv) m_pc_last = m_pend_data;
            if (e_lv) m_ldst_last = m_pend_data;
            if (e_wr) begin
                ref_data[i_ldst_addr]    = i_ldst_wrdata;
                ref_written[i_ldst_addr] = 1'b1;
            end
            m_pend = 0;
            if (e_rd) begin
                m_pend      = winner;
                m_pend_data = ref_read(e_addr);
            end
            if (e_pc_req && winner != 1) m_starve = (m_starve + 1 > MAXS) ? MAXS : m_starve + 1;
            else m_starve = 0;
            if (e_pc_req && e_ldst_req) m_conf = m_conf + 16'd1;
        end
    endtask

    task automatic step_check;
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic pc_rd, input logic [15:0] pc_addr, input logic ld_rd,
                         input logic ld_wr, input logic [15:0] ld_addr, input logic [15:0] wd);
        i_pc_rd       = pc_rd;
        i_pc_addr     = pc_addr;
        i_ldst_rd     = ld_rd;
        i_ldst_wr     = ld_wr;
        i_ldst_addr   = ld_addr;
        i_ldst_wrdata = wd;
    endtask

    initial begin
        m_starve = 0; m_pend = 0; m_pend_data = '0;
        m_pc_last = '0; m_ldst_last = '0; m_conf = '0;
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();

        // Reset state
        step_check();
        check("rst_pc_valid", 32'(o_pc_rddatavalid), 32'h0);
        check("rst_pc_data",  32'(o_pc_rddata),      32'h0);
        check("rst_ld_data",  32'(o_ldst_rddata),    32'h0);
        tick();
        reset = 1'b1;

        // Single fetch
        step_check();
        check("idle_mem_rd", 32'(o_mem_rd), 32'h0);
        tick();
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t1_mem_rd",   32'(o_mem_rd),     32'h1);
        check("t1_mem_addr", 32'(o_mem_addr),   32'h0010);
        check("t1_pc_wait",  32'(o_pc_waitreq), 32'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t1_pc_valid", 32'(o_pc_rddatavalid), 32'h1);
        check("t1_pc_data",  32'(o_pc_rddata),      32'h1234);
        tick();

        // Conflict: ldst write wins, pc follows
        drive(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0100, 16'hBEEF);
        step_check();
        check("t2_mem_wr",   32'(o_mem_wr),       32'h1);
        check("t2_wrdata",   32'(o_mem_wrdata),   32'hBEEF);
        check("t2_mem_addr", 32'(o_mem_addr),     32'h0100);
        check("t2_pc_wait",  32'(o_pc_waitreq),   32'h1);
        check("t2_ld_wait",  32'(o_ldst_waitreq), 32'h0);
        tick();
        drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t2_pc_grant", 32'(o_mem_addr),   32'h0020);
        check("t2_pc_wait2", 32'(o_pc_waitreq), 32'h0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t2_pc_data", 32'(o_pc_rddata), 32'h9CBA);
        tick();

        // Starvation relief after MAX_STARVE denials
        drive(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0200, 16'h0);
        for (int k = 0; k < 6; k++) begin
            step_check();
            if (k < 4) begin
                check("t3_pc_wait", 32'(o_pc_waitreq),   32'h1);
                check("t3_ld_wait", 32'(o_ldst_waitreq), 32'h0);
            end else if (k == 4) begin
                check("t3_pc_wait5", 32'(o_pc_waitreq),   32'h0);
                check("t3_ld_wait5", 32'(o_ldst_waitreq), 32'h1);
                check("t3_addr5",    32'(o_mem_addr),     32'h0004);
            end else begin
                check("t3_pc_wait6", 32'(o_pc_waitreq), 32'h1);
                check("t3_pc_data",  32'(o_pc_rddata),  32'h5555);
            end
            if (k >= 1 && k <= 4) check("t3_ld_data", 32'(o_ldst_rddata), 32'hAAAA);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        tick();

        // Alternating ldst / pc reads, no bubbles
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        step_check();
        tick();
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t4_ld_valid", 32'(o_ldst_rddatavalid), 32'h1);
        check("t4_ld_data",  32'(o_ldst_rddata),      32'hAAAA);
        check("t4_pc_valid", 32'(o_pc_rddatavalid),   32'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0);
        step_check();
        check("t4_pc_valid2", 32'(o_pc_rddatavalid),   32'h1);
        check("t4_pc_data2",  32'(o_pc_rddata),        32'h5555);
        check("t4_ld_valid2", 32'(o_ldst_rddatavalid), 32'h0);
        check("t4_ld_hold",   32'(o_ldst_rddata),      32'hAAAA);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t4_ld_valid3", 32'(o_ldst_rddatavalid), 32'h1);
        tick();

        // Reset drops an in-flight read
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        tick();
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t5_pc_valid", 32'(o_pc_rddatavalid), 32'h0);
        tick();
        drive(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0030, 16'h0);
        step_check();
        check("t5_mem_rd",   32'(o_mem_rd),       32'h0);
        check("t5_mem_wr",   32'(o_mem_wr),       32'h0);
        check("t5_pc_wait",  32'(o_pc_waitreq),   32'h0);
        check("t5_ld_wait",  32'(o_ldst_waitreq), 32'h0);
        check("t5_addr",     32'(o_mem_addr),     32'h0);
        check("t5_pc_data",  32'(o_pc_rddata),    32'h0);
        check("t5_ld_data",  32'(o_ldst_rddata),  32'h0);
        tick();
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t5_no_valid", 32'(o_pc_rddatavalid), 32'h0);
        tick();
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t5_resume_rd", 32'(o_mem_rd), 32'h1);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step_check();
        check("t5_resume_data", 32'(o_pc_rddata), 32'h1234);
        tick();

        // Randomized traffic, including occasional reset and illegal rd+wr
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  16'($urandom_range(0, 63)),
                  (sel >= 4 && sel <= 6) || sel == 9,
                  (sel == 7 || sel == 8 || sel == 9),
                  16'($urandom_range(0, 63)),
                  16'($urandom));
            step_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port (pc) and the load/store port (ldst).
- Sits between the cpu core and the memory, inside the top-level harness.
- Grants at most one request per cycle. Returns read data with a valid strobe. Applies back-pressure to the loser with a waitrequest.
- Guarantees fetch forward progress with a starvation counter.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_STARVE, 4, consecutive denied pc cycles after which pc gets priority for one grant (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- i_pc_addr  in  AW  fetch address.
- i_pc_rd  in  1  fetch read request.
- o_pc_waitreq  out  1  fetch request not accepted this cycle; hold request stable.
- o_pc_rddata  out  DW  fetch read data.
- o_pc_rddatavalid  out  1  o_pc_rddata valid this cycle.
- i_ldst_addr  in  AW  load/store address.
- i_ldst_rd  in  1  load request.
- i_ldst_wr  in  1  store request.
- i_ldst_wrdata  in  DW  store data.
- o_ldst_waitreq  out  1  ldst request not accepted this cycle.
- o_ldst_rddata  out  DW  load read data.
- o_ldst_rddatavalid  out  1  o_ldst_rddata valid this cycle.
- o_mem_addr  out  AW  memory address.
- o_mem_rd  out  1  memory read strobe.
- o_mem_wr  out  1  memory write strobe.
- o_mem_wrdata  out  DW  memory write data.
- i_mem_rddata  in  DW  memory read data, valid exactly 1 cycle after o_mem_rd.

Behaviour:
- Request: pc_req = i_pc_rd. ldst_req = i_ldst_rd | i_ldst_wr. i_ldst_rd and i_ldst_wr both high is illegal; the write wins and the read is ignored.
- Grant is combinational from the current requests and the starve counter:
  - ldst_req only -> grant ldst.
  - pc_req only -> grant pc.
  - both, starve_cnt < MAX_STARVE -> grant ldst.
  - both, starve_cnt == MAX_STARVE -> grant pc.
- Memory drive, same cycle as the grant:
  - o_mem_addr = granted requester's address; 0 when no grant.
  - o_mem_rd = 1 for a granted read (pc, or ldst with rd only).
  - o_mem_wr = 1 for a granted ldst write.
  - o_mem_wrdata = i_ldst_wrdata.
- Waitrequest (combinational): o_X_waitreq = X_req & ~grant_X. It is 0 when there is no request.
- Starve counter (4 bits, registered):
  - pc_req & ~grant_pc -> increment, saturating at MAX_STARVE.
  - grant_pc or ~pc_req -> clear to 0.
- Read return (registered tag, 1-cycle latency):
  - rd_tag register records {pc read, ldst read, none} for each granted read.
  - The next cycle, the matching o_X_rddatavalid = 1 and o_X_rddata = i_mem_rddata.
  - The other requester's rddata holds its last value; its valid stays 0.
- Writes produce no valid pulse.
- Back-to-back grants every cycle are allowed: full throughput, one access per cycle.
- A request granted in cycle N returns data in N+1, even if the requester changes its inputs in N+1.
- Reset (reset == 0 at a clock edge):
  - starve_cnt = 0, rd_tag = none, both rddatavalid = 0, both rddata = 0.
  - A read in flight when reset asserts is dropped: no valid pulse after reset.
  - While reset is low, o_mem_rd, o_mem_wr and both waitreq are forced 0.
- No state machine beyond rd_tag (states IDLE, PC_PEND, LDST_PEND) and starve_cnt.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds output o_conflict_cnt [15:0].
  - Increments on every cycle with pc_req & ldst_req, wrapping 0xFFFF -> 0.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Idle, then i_pc_rd=1, addr=0x0010, memory word 0x1234 -> o_mem_rd=1 with addr 0x0010 in the same cycle, o_pc_waitreq=0; next cycle o_pc_rddatavalid=1, o_pc_rddata=0x1234.
2. Simultaneous pc read 0x0020 and ldst write 0x0100 data 0xBEEF -> ldst granted (o_mem_wr=1, wrdata 0xBEEF), o_pc_waitreq=1; pc granted the following cycle once ldst drops.
3. Starvation: ldst reads continuously while pc requests, MAX_STARVE=4 -> pc waitreq high for 4 cycles, pc granted on the 5th, ldst waitreq=1 that cycle, starve_cnt back to 0.
4. Alternating ldst read 0x0200 (data 0xAAAA) then pc read 0x0004 (data 0x5555) on consecutive cycles -> ldst valid with 0xAAAA then pc valid with 0x5555, no cross-routing, no bubbles.
5. pc read granted, reset driven low the next edge -> no o_pc_rddatavalid after reset, all outputs 0, starve_cnt 0; normal operation resumes after reset returns high.
6. With MEM_ARB_PERF_EN: 3 conflict cycles -> o_conflict_cnt=3; preload 0xFFFF plus 1 conflict -> 0x0000.
